seg_scan_driver: RTL
====================

// Module: seg_scan_driver
// PURPOSE
//   Display-side end of the 7-bit segment bus. Holds NDIG per-digit segment
//   patterns, written by upstream muxes/game logic. Time-multiplexes them onto
//   one shared seg[6:0] bus plus one-hot anode enables for a common-anode
//   board display. Includes a dead-time blank between digits to prevent ghosting.
// PARAMETERS
//   NDIG      4      number of digits scanned (2..8)
//   SLOT_CYC  65536  clk cycles each digit is enabled (>= DEAD_CYC+2)
//   DEAD_CYC  64     cycles at start of each slot with all anodes off
// PORTS
//   clk         in   1        system clock, rising edge
//   rst_n       in   1        asynchronous active-low reset
//   wr_en       in   1        write strobe, one digit per cycle
//   wr_addr     in   3        digit index; values >= NDIG are ignored
//   wr_hex      in   1        1: wr_data[3:0] is a hex nibble to decode; 0: raw pattern
//   wr_data     in   7        raw pattern {g,f,e,d,c,b,a}, 1 = lit, or nibble in [3:0]
//   blank       in   NDIG     per-digit blank; 1 forces that digit dark while set
//   seg         out  7        segment cathodes, active-low, registered
//   an          out  NDIG     anode enables, active-low, one-hot-low or all-high, registered
//   slot_tick   out  1        1-cycle pulse on the first cycle of each new slot
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - slot counter 0, digit index 0, all digit regs 7'h00
//     - seg = 7'h7F, an = all 1s, slot_tick = 0
//   Slot counter:
//     - counts 0..SLOT_CYC-1, then wraps to 0
//     - on wrap, digit index += 1, wrapping NDIG-1 -> 0; slot_tick = 1 that cycle
//   Anode output, registered from next-state:
//     - counter < DEAD_CYC: an = all 1s
//     - otherwise: an[idx] = 0 and all other bits 1
//     - blank[idx] = 1 keeps an = all 1s for the whole slot (sampled every cycle)
//   Segment output:
//     - seg = ~digit_reg[idx] every cycle, registered
//     - forced to 7'h7F while an is all 1s
//   Writes:
//     - wr_en=1 and wr_addr<NDIG: reg[wr_addr] <= wr_hex ? hex7_decode(wr_data[3:0]) : wr_data
//       on that edge; wr_data[6:4] is don't-care when wr_hex=1
//     - wr_addr >= NDIG: no effect
//     - write to the digit being displayed is visible on seg 2 cycles after the strobe
//       (reg, then output reg); no tearing, no stall of the scan
//   Simultaneous write and slot wrap:
//     - both take effect; new index selects the already-updated reg on the following cycle
//   Mid-operation reset: outputs go dark immediately (async); all stored patterns are lost.
//   No handshake back-pressure: writer may strobe every cycle.
//   Width rules:
//     - counter width = $clog2(SLOT_CYC)
//     - index width = $clog2(NDIG), wrap explicit (NDIG need not be a power of 2)
// STRUCTURE
//   Shared package: SEG_OFF (7'h7F active-low), SEG_BLANK (7'h00 internal),
//   HEX_FONT[16] table.
//   Sub-module hex7_decode: 4-bit nibble -> 7-bit active-high pattern, combinational,
//   reads HEX_FONT.
//   Top: slot counter, index counter, digit register file, output registers.
// TESTING (NDIG=4, SLOT_CYC=8, DEAD_CYC=2)
//   1. Reset: hold rst_n=0 -> seg=7'h7F, an=4'hF. Release and run 40 cycles ->
//      an sequence per slot is F,F,E x6, then F,F,D x6, then B, then 7, then wraps to E.
//   2. Hex write: wr_en, addr=0, hex=1, data=4'h8 -> during digit-0 enabled cycles,
//      seg=7'h00. With data=4'h1 -> seg=~7'h06=7'h79.
//   3. Raw write: addr=2, hex=0, data=7'h49 -> seg=7'h36 only while an=4'hB.
//      Digit 2 then written 7'h00 mid-slot -> seg=7'h7F two cycles later, an unchanged.
//   4. Bad address: wr_addr=5, data=7'h7F -> no digit reg changes; scan output
//      identical to preceding frame.
//   5. Blank: blank=4'b0010 -> an never equals 4'hD; other digits unaffected;
//      slot_tick still pulses every 8 cycles.
//   6. Reset mid-slot: assert rst_n=0 at counter=5 of digit 3 -> an=4'hF, seg=7'h7F
//      same cycle. After release, digit regs read 0 and scan restarts at digit 0.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the segment scan driver.
//   SEG_OFF   : active-low cathode pattern with every segment dark
//   SEG_BLANK : active-high stored pattern with every segment unlit
//   HEX_FONT  : nibble -> active-high {g,f,e,d,c,b,a} glyphs 0-9, A, b, C, d, E, F
package seg_scan_driver_pkg;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] HEX_FONT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_scan_driver_hex7_decode.sv
// Combinational hex-nibble to seven-segment glyph lookup.
//   nibble : 4-bit value to display
//   pattern: active-high segment pattern {g,f,e,d,c,b,a}
module hex7_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = HEX_FONT[nibble];
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a common-anode multi-digit seven-segment display.
// Stores one pattern per digit and scans them onto a shared cathode bus with a
// dark dead-time at the start of every slot to suppress ghosting.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   wr_en      : write strobe, one digit per cycle
//   wr_addr    : digit index; values >= NDIG are ignored
//   wr_hex     : 1 = decode wr_data[3:0] as hex, 0 = wr_data is a raw pattern
//   wr_data    : raw active-high pattern {g,f,e,d,c,b,a} or nibble in [3:0]
//   blank      : per-digit force-dark
//   seg        : active-low cathodes, registered
//   an         : active-low anode enables, one-hot-low or all-high, registered
//   slot_tick  : single-cycle pulse on the first cycle of each new slot
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SLOT_CYC = 65536,
  parameter int DEAD_CYC = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [2:0]      wr_addr,
  input  logic            wr_hex,
  input  logic [6:0]      wr_data,
  input  logic [NDIG-1:0] blank,
  output logic [6:0]      seg,
  output logic [NDIG-1:0] an,
  output logic            slot_tick
);

  localparam int CW = $clog2(SLOT_CYC);
  localparam int IW = $clog2(NDIG);

  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYC - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [6:0]      digit_q [NDIG];
  logic [6:0]      digit_d [NDIG];
  logic [6:0]      seg_q, seg_d;
  logic [NDIG-1:0] an_q, an_d;
  logic            slot_tick_q, slot_tick_d;

  logic            wrap;
  logic            wr_ok;
  logic [6:0]      dec_pattern;

  hex7_decode u_hex7_decode (
    .nibble  (wr_data[3:0]),
    .pattern (dec_pattern)
  );

  always_comb begin
    wrap        = (cnt_q == CNT_LAST);
    cnt_d       = wrap ? '0 : cnt_q + CW'(1);
    slot_tick_d = wrap;

    idx_d = idx_q;
    if (wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    wr_ok   = wr_en && ({29'd0, wr_addr} < 32'(NDIG));
    digit_d = digit_q;
    if (wr_ok) begin
      digit_d[wr_addr[IW-1:0]] = wr_hex ? dec_pattern : wr_data;
    end

    // Outputs are computed from next-state so they line up with cnt_q/idx_q.
    // The pattern comes from the current register file, which gives the
    // two-edge write-to-display latency without tearing.
    an_d = '1;
    if ((cnt_d >= CNT_DEAD) && !blank[idx_d]) begin
      an_d[idx_d] = 1'b0;
    end
    seg_d = (&an_d) ? SEG_OFF : ~digit_q[idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      seg_q       <= SEG_OFF;
      an_q        <= '1;
      slot_tick_q <= 1'b0;
      for (int unsigned i = 0; i < NDIG; i++) begin
        digit_q[i] <= SEG_BLANK;
      end
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      slot_tick_q <= slot_tick_d;
      digit_q     <= digit_d;
    end
  end

  assign seg       = seg_q;
  assign an        = an_q;
  assign slot_tick = slot_tick_q;

endmodule
